// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter draining a show-ahead byte FIFO.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between D7 and the stop bit.
module uart_tx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_d,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       txd,
    output logic       busy
);
    // state  | meaning
    // IDLE   | line high, pop a byte as soon as the FIFO is non-empty
    // START  | start bit, line low
    // DATA   | eight data bits, LSB first
    // PARITY | even parity of the byte (UART_TX_PARITY_EN only)
    // STOP   | stop bit, line high

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_TC = BW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [BW-1:0]   baudcnt_q, baudcnt_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            baud_tc;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    assign fifo_rd_en = (state_q == IDLE) & ~fifo_empty & ~rst;
    assign baud_tc    = (baudcnt_q == BAUD_TC);
    assign txd        = txd_q;
    assign busy       = busy_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        baudcnt_d = baud_tc ? '0 : baudcnt_q + BW'(1);
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                baudcnt_d = '0;
                txd_d     = 1'b1;
                if (!fifo_empty) begin
                    shreg_d = fifo_d;
                    state_d = START;
                    txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_d;
`endif
                end
            end
            START: begin
                if (baud_tc) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                    txd_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (baud_tc) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tc) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                baudcnt_d = '0;
                txd_d     = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            baudcnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            baudcnt_q <= baudcnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line/pop model derived from frame timing rules,
// plus an independent mid-bit line decoder and pop-spacing checks.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int SLOTS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = SLOTS * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_d;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       txd;
    logic       busy;

    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] mem [64];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    logic       empty_q = 1'b1;

    always #5 clk = ~clk;

    uart_tx #(.CLK_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_d     (fifo_d),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .txd        (txd),
        .busy       (busy)
    );

    // show-ahead FIFO whose empty flag is registered from the old pointers
    assign fifo_d     = mem[rd_ptr];
    assign fifo_empty = empty_q;

    always @(posedge clk) begin
        empty_q <= (wr_ptr == rd_ptr);
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 6'd1;
        end
        if (fifo_rd_en) rd_ptr <= rd_ptr + 6'd1;
    end

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         next_ok  = 0;
    bit         armed    = 1'b0;
    bit         fr_on    = 1'b0;
    int         fr_t     = 0;
    logic [7:0] fr_b     = 8'h00;
    logic [7:0] wq [$];
    int         pops [$];
    bit         in_fr;
    int         o, slot;
    logic       e_txd, e_busy, e_rd;
    bit         dec_on   = 1'b0;
    int         dec_s    = 0;
    int         d_o, d_slot;
    logic [7:0] dec_b    = 8'h00;
    logic       dec_p    = 1'b0;
    logic       prev_txd = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        in_fr = fr_on && (cyc > fr_t) && (cyc <= fr_t + FRAME);
        e_txd = 1'b1;
        if (in_fr) begin
            o    = cyc - fr_t - 1;
            slot = o / N;
            if (slot == 0)                 e_txd = 1'b0;
            else if (slot <= 8)            e_txd = fr_b[slot-1];
            else if (PAR && slot == 9)     e_txd = ^fr_b;
            else                           e_txd = 1'b1;
        end
        e_busy = in_fr;
        e_rd   = !rst && !fifo_empty && (cyc >= next_ok);

        if (armed) begin
            check_eq("txd",   32'(txd),        32'(e_txd));
            check_eq("busy",  32'(busy),       32'(e_busy));
            check_eq("rd_en", 32'(fifo_rd_en), 32'(e_rd));
            if (fifo_rd_en) pops.push_back(cyc);
        end

        if (rst) begin
            fr_on   = 1'b0;
            next_ok = cyc + 1;
            armed   = 1'b1;
        end else if (e_rd) begin
            fr_on   = 1'b1;
            fr_t    = cyc;
            fr_b    = (wq.size() > 0) ? wq.pop_front() : 8'h00;
            next_ok = cyc + FRAME + 1;
        end

        if (rst) dec_on = 1'b0;
        else if (!dec_on && prev_txd && !txd) begin
            dec_on = 1'b1;
            dec_s  = cyc;
        end
        if (dec_on && !rst) begin
            d_o = cyc - dec_s;
            if (d_o % N == N / 2) begin
                d_slot = d_o / N;
                if (d_slot == 0) check_eq("dec_start", 32'(txd), 32'(0));
                else if (d_slot <= 8) dec_b[d_slot-1] = txd;
                else if (PAR && d_slot == 9) dec_p = txd;
                if (d_slot == SLOTS - 1) begin
                    check_eq("dec_stop", 32'(txd), 32'(1));
                    check_eq("dec_byte", 32'(dec_b), 32'(fr_b));
                    if (PAR) check_eq("dec_parity", 32'(dec_p), 32'(^fr_b));
                    dec_on = 1'b0;
                end
            end
        end
        prev_txd = txd;
        cyc++;
    end

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wdata = b;
        wq.push_back(b);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (pops.size() > 0) break;
            @(posedge clk); #1;
        end
        check_eq("pop_wait", 32'(pops.size() > 0), 32'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(100);

        pops.delete();
        push(8'h55);
        idle(FRAME + 20);
        check_eq("single_pop_count", 32'(pops.size()), 32'(1));

        pops.delete();
        push(8'hA3);
        push(8'h00);
        push(8'hFF);
        idle(3 * (FRAME + 1) + 20);
        check_eq("burst_pop_count", 32'(pops.size()), 32'(3));
        if (pops.size() == 3) begin
            check_eq("burst_gap1", 32'(pops[1] - pops[0]), 32'(FRAME + 1));
            check_eq("burst_gap2", 32'(pops[2] - pops[1]), 32'(FRAME + 1));
        end

        pops.delete();
        push(8'h0F);
        wait_pop(20);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);
        push(8'h81);
        idle(FRAME + 20);
        check_eq("abort_pop_count", 32'(pops.size()), 32'(2));

        pops.delete();
        rst = 1'b1;
        push(8'h3C);
        idle(6);
        rst = 1'b0;
        idle(FRAME + 20);
        check_eq("rst_hold_pop_count", 32'(pops.size()), 32'(1));

        pops.delete();
        push(8'h07);
        wait_pop(20);
        idle(15);
        push(8'hC4);
        idle(2 * FRAME + 20);
        check_eq("midframe_pop_count", 32'(pops.size()), 32'(2));
        if (pops.size() == 2)
            check_eq("midframe_gap", 32'(pops[1] - pops[0]), 32'(FRAME + 1));

        for (int i = 0; i < 20; i++) begin
            push(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 60));
        end
        idle(20 * (FRAME + 1) + 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART path. It drains bytes from the transmit-side byte FIFO through that FIFO's read port (`rd_d` / `rd_en` / `rd_empty`) and shifts each byte out on `txd`. The frame is 8N1, LSB first, by default. It sits between the TX FIFO and the board-level TX pin and is the consumer counterpart of the host/CPU writer that fills the FIFO.

## Interface
Parameters:
- `CLK_PER_BIT`, default 868: clk cycles per serial bit (100 MHz / 115200). Legal range 4..65535.

Ports:
- Reset `rst`, synchronous, active-high; clock `clk`.
- `fifo_d`, input, 8 bits: FIFO read data, show-ahead (valid combinationally while `fifo_empty` = 0).
- `fifo_empty`, input, 1 bit: FIFO empty flag, registered inside the FIFO, lags pointer updates by one cycle.
- `fifo_rd_en`, output, 1 bit: one-cycle pop strobe.
- `txd`, output, 1 bit: serial line, idle high, registered.
- `busy`, output, 1 bit: high while a frame is in flight.

## Operation
- States: `IDLE`, `START`, `DATA`, `STOP`, plus `PARITY` when enabled.
- Registers:
  - `shreg[7:0]`
  - `bitcnt[2:0]`
  - `baudcnt`, width `$clog2(CLK_PER_BIT)`
- `IDLE`:
  - `txd` = 1.
  - If `fifo_empty` = 0: `fifo_rd_en` = 1 for that cycle, `shreg` <= `fifo_d`, `baudcnt` <= 0, next state is `START`.
  - `fifo_rd_en` is combinational: (state == `IDLE`) & ~`fifo_empty` & ~`rst`. It is never high outside `IDLE`.
- Each non-idle state lasts exactly `CLK_PER_BIT` cycles. `baudcnt` counts 0..`CLK_PER_BIT`-1 and the state advances on the terminal count, with `baudcnt` wrapping to 0.
- `START`: `txd` = 0. Next state is `DATA` with `bitcnt` = 0.
- `DATA`:
  - `txd` = `shreg[0]`.
  - On terminal count: `shreg` shifts right and `bitcnt` increments.
  - After `bitcnt` = 7 completes, next state is `STOP` (or `PARITY` when enabled).
- `STOP`: `txd` = 1. Next state is `IDLE`.
- `busy` = (state != `IDLE`).
- Pop spacing: consecutive `fifo_rd_en` pulses are at least 10·`CLK_PER_BIT`+1 cycles apart. This is far beyond the two cycles needed for the lagging `fifo_empty`, so no double-pop can occur on the last byte.
- Because the FIFO data is show-ahead, the byte latched in the pop cycle is the byte removed.
- `fifo_d` is ignored outside the pop cycle.

## Timing
- Reset values: `txd` = 1, `busy` = 0, `fifo_rd_en` = 0, state `IDLE`, all counters 0.
- Latency: the pop occurs in cycle T. `txd` falls at the edge ending T, so it is low from T+1. The start bit spans T+1..T+`CLK_PER_BIT`.
- Bit k (k = 0..7) occupies cycles T+1+(k+1)·`CLK_PER_BIT` .. T+(k+2)·`CLK_PER_BIT`.
- The stop bit ends at T+10·`CLK_PER_BIT`. The earliest next pop is cycle T+10·`CLK_PER_BIT`+1, so the effective stop time is `CLK_PER_BIT`+1 cycles.
- Frame period under continuous data: 10·`CLK_PER_BIT`+1 cycles.
- FIFO becomes non-empty (`fifo_empty` falls in cycle W): the pop happens in W itself if state is `IDLE`.
- FIFO empty at the end of `STOP`: remain in `IDLE` with `txd` = 1, no pop.
- Reset mid-frame: at the reset edge, `txd` returns to 1 and the state goes to `IDLE`. The popped byte is dropped and the line glitch is accepted. The first pop after reset deassertion is no earlier than the cycle after `rst` falls.
- `rst` high with `fifo_empty` = 0: `fifo_rd_en` stays 0.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A `PARITY` state of `CLK_PER_BIT` cycles is inserted between the last data bit and `STOP`.
  - `txd` = XOR of the 8 data bits (even parity), computed at the pop cycle and held in a register.
  - Frame period becomes 11·`CLK_PER_BIT`+1.
- Undefined: no `PARITY` state or parity register is built, and the frame is 8N1 as above.

## Test plan
All scenarios use `CLK_PER_BIT` = 4.
- Reset for 3 cycles with the FIFO empty -> `txd` = 1, `busy` = 0, `fifo_rd_en` = 0 throughout, and no activity for 100 cycles.
- FIFO holds 0x55, pop at cycle T -> `txd` = 0 for T+1..T+4, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high T+37..T+40, `busy` falls at T+41, exactly one `fifo_rd_en` pulse.
- FIFO preloaded with 0xA3, 0x00, 0xFF -> three pops 41 cycles apart. Decoded bytes are 0xA3, 0x00, 0xFF. No fourth pop, including across the cycle where `fifo_empty` lags.
- Assert `rst` one cycle during bit 3 of 0x0F -> `txd` = 1 the next cycle and state `IDLE`. A new byte 0x81 written afterwards transmits correctly.
- A byte is written while a frame is in progress -> its pop occurs exactly in the cycle after the stop bit ends, and no pop happens earlier.
- With `UART_TX_PARITY_EN`, send 0x07 -> the parity bit is 1 for 4 cycles after D7, and the frame period is 45 cycles.
